// File: rtl/spi3w_pkg.sv
// Shared definitions for the 3-wire SPI register slave: FSM states and 24-bit frame layout.
package spi3w_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    WDATA,
    RDATA,
    WAIT_CSN
  } state_t;

  localparam int RW_BIT     = 23;
  localparam int W1W0_MSB   = 22;
  localparam int W1W0_LSB   = 21;
  localparam int ADDR_MSB   = 20;
  localparam int ADDR_LSB   = 8;
  localparam int INSTR_BITS = 16;
  localparam int FRAME_BITS = 24;
  localparam int DATA_BITS  = FRAME_BITS - INSTR_BITS;
  localparam int CNT_W      = 5;

endpackage

// File: rtl/spi3w_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus one-clk rise/fall pulses for SCLK and CSN.
// Reset presets the chains so CSN reads high and SCLK reads low.
module spi3w_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_csn,
  input  logic i_sclk,
  input  logic i_sdi,
  output logic o_csn,
  output logic o_sdi,
  output logic o_csn_rise,
  output logic o_csn_fall,
  output logic o_sclk_rise,
  output logic o_sclk_fall
);

  logic [1:0] r_csn_sync;
  logic [1:0] r_sclk_sync;
  logic [1:0] r_sdi_sync;
  logic       r_csn_d;
  logic       r_sclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csn_sync  <= 2'b11;
      r_sclk_sync <= 2'b00;
      r_sdi_sync  <= 2'b00;
      r_csn_d     <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_csn_sync  <= {r_csn_sync[0], i_csn};
      r_sclk_sync <= {r_sclk_sync[0], i_sclk};
      r_sdi_sync  <= {r_sdi_sync[0], i_sdi};
      r_csn_d     <= r_csn_sync[1];
      r_sclk_d    <= r_sclk_sync[1];
    end
  end

  assign o_csn       = r_csn_sync[1];
  assign o_sdi       = r_sdi_sync[1];
  assign o_csn_rise  = r_csn_sync[1] & ~r_csn_d;
  assign o_csn_fall  = ~r_csn_sync[1] & r_csn_d;
  assign o_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
  assign o_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;

endmodule

// File: rtl/spi3w_reg_slave.sv
// 3-wire SPI register slave: 24-bit frames (R/W, W1W0, 13-bit address, 8-bit data).
// Optional macro SPI_SLV_TIMEOUT_EN aborts a frame whose SCLK stalls for TIMEOUT_CYC clks.
module spi3w_reg_slave
  import spi3w_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_csn,
  input  logic              spi_clk,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              frame_done,
  output logic              frame_err
);

  logic w_csn, w_sdi, w_csn_rise, w_csn_fall, w_sclk_rise, w_sclk_fall;

  spi3w_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_csn      (spi_csn),
    .i_sclk     (spi_clk),
    .i_sdi      (spi_sdi),
    .o_csn      (w_csn),
    .o_sdi      (w_sdi),
    .o_csn_rise (w_csn_rise),
    .o_csn_fall (w_csn_fall),
    .o_sclk_rise(w_sclk_rise),
    .o_sclk_fall(w_sclk_fall)
  );

  state_t                r_state, w_state_next;
  logic [FRAME_BITS-2:0] r_shift;
  logic [FRAME_BITS-1:0] w_frame;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_tx, r_wr_data;
  logic [ADDR_W-1:0]     r_addr;
  logic [1:0]            r_settle;
  logic r_wr_en, r_rd_en, r_rd_load, r_done, r_err, r_sdo, r_oe, r_good, r_armed;
  logic w_start, w_shift, w_wr_fire, w_rd_fire, w_err_fire, w_done_fire, w_good_set, w_abort;

  assign w_frame = {r_shift, w_sdi};

`ifdef SPI_SLV_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_active;

  assign w_to_active = !w_csn && (r_state != IDLE) && (r_state != WAIT_CSN);
  assign w_abort     = w_to_active && !w_sclk_rise && !w_sclk_fall &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_to_cnt <= '0;
    else if (!w_to_active || w_sclk_rise || w_sclk_fall || w_csn_fall || w_abort)
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_wr_fire    = 1'b0;
    w_rd_fire    = 1'b0;
    w_err_fire   = 1'b0;
    w_done_fire  = 1'b0;
    w_good_set   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A rise in the same clk as the CSN fall is bit 0 of the new frame.
        if (w_csn_fall && r_armed) begin
          w_state_next = INSTR;
          w_start      = 1'b1;
          w_shift      = w_sclk_rise;
        end
      end
      INSTR: begin
        if (w_csn_rise) begin
          w_err_fire   = 1'b1;
          w_state_next = IDLE;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
          if (r_cnt == CNT_W'(INSTR_BITS - 1)) begin
            if (w_frame[W1W0_MSB-DATA_BITS:W1W0_LSB-DATA_BITS] != 2'b00) begin
              w_err_fire   = 1'b1;
              w_state_next = WAIT_CSN;
            end else if (w_frame[RW_BIT-DATA_BITS]) begin
              w_rd_fire    = 1'b1;
              w_state_next = RDATA;
            end else begin
              w_state_next = WDATA;
            end
          end
        end
      end
      WDATA, RDATA: begin
        if (w_csn_rise) begin
          w_err_fire   = 1'b1;
          w_state_next = IDLE;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
          if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
            w_good_set   = 1'b1;
            w_state_next = WAIT_CSN;
            // Instruction bits have now shifted up to their full-frame positions.
            if (r_state == WDATA && w_frame[RW_BIT:W1W0_LSB] == 3'b000)
              w_wr_fire = 1'b1;
          end
        end
      end
      WAIT_CSN: begin
        if (w_csn_rise) begin
          w_done_fire  = r_good;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_abort) begin
      w_err_fire   = 1'b1;
      w_state_next = WAIT_CSN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_tx      <= '0;
      r_wr_data <= '0;
      r_addr    <= '0;
      r_settle  <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_load <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_sdo     <= 1'b0;
      r_oe      <= 1'b0;
      r_good    <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_wr_en   <= w_wr_fire;
      r_rd_en   <= w_rd_fire;
      r_rd_load <= r_rd_en;
      r_done    <= w_done_fire;
      r_err     <= w_err_fire;
      // Ignore the synthetic CSN fall seen when reset releases mid-frame; arm on CSN high.
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      if (r_settle == 2'd3 && w_csn) r_armed <= 1'b1;
      if (w_shift) r_shift <= w_frame[FRAME_BITS-2:0];
      if (w_start)      r_cnt <= CNT_W'(w_sclk_rise);
      else if (w_shift) r_cnt <= r_cnt + CNT_W'(1);
      if (w_start)         r_good <= 1'b0;
      else if (w_good_set) r_good <= 1'b1;
      if (w_rd_fire) begin
        r_addr <= ADDR_W'(w_frame[ADDR_MSB-DATA_BITS:ADDR_LSB-DATA_BITS]);
      end else if (w_wr_fire) begin
        r_addr    <= ADDR_W'(w_frame[ADDR_MSB:ADDR_LSB]);
        r_wr_data <= DATA_W'(w_frame[DATA_BITS-1:0]);
      end
      if (w_csn_rise || w_abort || r_state == IDLE) begin
        r_oe  <= 1'b0;
        r_sdo <= 1'b0;
      end else if (r_rd_load) begin
        r_tx <= reg_rd_data;
      end else if (r_state == RDATA && w_sclk_fall) begin
        r_sdo <= r_tx[DATA_W-1];
        r_tx  <= {r_tx[DATA_W-2:0], 1'b0};
        r_oe  <= 1'b1;
      end
    end
  end

  assign spi_sdo     = r_sdo;
  assign spi_sdo_oe  = r_oe;
  assign reg_wr_en   = r_wr_en;
  assign reg_rd_en   = r_rd_en;
  assign reg_addr    = r_addr;
  assign reg_wr_data = r_wr_data;
  assign frame_done  = r_done;
  assign frame_err   = r_err;

endmodule

// File: doc/spi3w_reg_slave.md
SPI3W_REG_SLAVE -- requirements
Module: spi3w_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 13: register address width.
REQ-002 SHALL have parameter DATA_W, default 8: register data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096: clk cycles without an SCLK edge before a frame is aborted (used only under SPI_SLV_TIMEOUT_EN).
REQ-004 SHALL have port clk, input, 1: system clock; single clock domain; SCLK ≤ clk/8.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports spi_csn, spi_clk and spi_sdi, each input, 1: chip select (active-low), serial clock (idle low), and serial data in; all asynchronous to clk.
REQ-007 SHALL have ports spi_sdo, output, 1 (serial data out) and spi_sdo_oe, output, 1 (pad tristate enable, 1 = drive).
REQ-008 SHALL have ports reg_wr_en, output, 1 (one-clk write strobe), reg_rd_en, output, 1 (one-clk read strobe), reg_addr, output, ADDR_W, reg_wr_data, output, DATA_W, and reg_rd_data, input, DATA_W (valid one clk after reg_rd_en).
REQ-009 SHALL have ports frame_done, output, 1 (one-clk pulse on good frame end) and frame_err, output, 1 (one-clk pulse on aborted or unsupported frame).

Function
REQ-010 SHALL pass spi_csn, spi_clk and spi_sdi through 2-flop synchronizers, then derive one-clk rise and fall pulses for SCLK and CSN.
REQ-011 SHALL sample SDI on each synchronized SCLK rise, MSB first.
REQ-012 SHALL use a 24-bit frame: bit23 R/W (1 = read), bits22:21 W1W0, bits20:8 address, bits7:0 data.
REQ-013 SHALL implement FSM states IDLE, INSTR, WDATA, RDATA and WAIT_CSN.
REQ-014 IDLE SHALL go to INSTR on CSN fall; the bit counter clears to 0.
REQ-015 INSTR SHALL run for 16 rises; on the 16th rise: if W1W0 != 00, go to WAIT_CSN and pulse frame_err; if R/W = 0, go to WDATA; if R/W = 1, go to RDATA and pulse reg_rd_en with reg_addr = instruction[12:0].
REQ-016 WDATA SHALL run for 8 rises; on the 8th rise, pulse reg_wr_en with reg_addr and reg_wr_data latched from the frame in the same clk, then go to WAIT_CSN.
REQ-017 RDATA SHALL load reg_rd_data into the output shifter one clk after reg_rd_en.
REQ-018 RDATA SHALL, on each SCLK fall, assert spi_sdo_oe and drive the next bit (bit7 first).
REQ-019 RDATA SHALL go to WAIT_CSN after the 8th SCLK rise.
REQ-020 WAIT_CSN SHALL ignore further SCLK edges, pulse frame_done on CSN rise when the frame was good, and return to IDLE.
REQ-021 CSN rise in INSTR, WDATA or RDATA (short frame) SHALL produce no write strobe, pulse frame_err and go to IDLE.
REQ-022 spi_sdo_oe SHALL deassert in the clk following CSN rise detection, and SHALL be 0 in every state except RDATA and WAIT_CSN-after-read.
REQ-023 CSN fall and SCLK rise detected in the same clk SHALL start the frame and count that rise as bit 0.
REQ-024 Strobes SHALL never assert more than once per frame.

Reset
REQ-025 While rst_n = 0, the FSM SHALL be in IDLE.
REQ-026 While rst_n = 0, all strobes, spi_sdo, spi_sdo_oe, reg_addr and reg_wr_data SHALL be 0.
REQ-027 While rst_n = 0, the synchronizers SHALL be preset so that csn reads 1 and sclk reads 0.
REQ-028 If reset is released while spi_csn is low, the block SHALL wait for CSN high and then a fresh CSN fall before decoding; the partial frame SHALL be discarded and no frame_err asserted.

Configuration
REQ-029 With macro SPI_SLV_TIMEOUT_EN defined, a counter SHALL clear on each SCLK edge and on CSN fall.
REQ-030 With SPI_SLV_TIMEOUT_EN defined, reaching TIMEOUT_CYC while CSN is low and the FSM is not IDLE SHALL pulse frame_err, deassert spi_sdo_oe and enter WAIT_CSN.
REQ-031 Without SPI_SLV_TIMEOUT_EN, no timeout counter SHALL exist and frames wait indefinitely.

Structure
REQ-032 Package spi3w_pkg SHALL hold the FSM state enum, the frame field positions (RW_BIT=23, W1W0 msb/lsb, ADDR_MSB=20, ADDR_LSB=8), INSTR_BITS=16 and FRAME_BITS=24.
REQ-033 Sub-module spi3w_sync_edge SHALL contain the synchronizer and edge detection; spi3w_reg_slave instantiates it once.

Verification
REQ-034 Write frame 0x000803 -> one reg_wr_en, reg_addr=0x008, reg_wr_data=0x03, frame_done at CSN rise, spi_sdo_oe stays 0.
REQ-035 Read frame 0x800D with reg_rd_data=0x5A -> reg_rd_en once, reg_addr=0x00D, SDO bits 0,1,0,1,1,0,1,0 on falls 16..23, oe drops after CSN rise.
REQ-036 CSN rises after 10 bits of 0x0014xx -> no strobes, frame_err pulse, FSM IDLE.
REQ-037 Frame 0x200500 (W1W0=01) -> frame_err after bit 16, no reg_wr_en, remaining SCLKs ignored.
REQ-038 rst_n pulsed low at bit 20 of a write -> no strobe; next full frame 0x00FF01 writes addr 0x0FF data 0x01.
REQ-039 With SPI_SLV_TIMEOUT_EN and TIMEOUT_CYC=64, SCLK stalled 100 clks after bit 5 -> frame_err at cycle 64; without the macro no pulse occurs.
